// File: rtl/riscv_pkg.sv
// Shared memory-stage types: FSM states, funct3 encodings, trap causes
// and the funct3 legality check used at accept time.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Doubleword and LWU accesses only exist on a 64-bit datapath.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store,
                                        input int unsigned xlen);
        logic bad;
        bad = is_store ? f3[2] : (f3 == 3'b111);
        if (xlen == 32 && (f3 == F3_D || (!is_store && f3 == F3_WU)))
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: moves the addressed bytes to bit 0 and
// sign- or zero-extends them according to funct3.
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0]              i_rdata,
    input  logic [$clog2(XLEN/8)-1:0]    i_offset,
    input  logic [2:0]                   i_funct3,
    output logic [XLEN-1:0]              o_result
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_result = w_shifted;
        case (i_funct3)
            F3_B:    o_result = XLEN'($signed(w_shifted[7:0]));
            F3_H:    o_result = XLEN'($signed(w_shifted[15:0]));
            F3_W:    o_result = XLEN'($signed(w_shifted[31:0]));
            F3_BU:   o_result = XLEN'(w_shifted[7:0]);
            F3_HU:   o_result = XLEN'(w_shifted[15:0]);
            F3_WU:   o_result = XLEN'(w_shifted[31:0]);
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues load/store requests over a valid/ready
// port, formats load data, detects traps and registers the writeback.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic [XLEN-1:0]     pc_in,
    input  logic [4:0]          rd_in,
    input  logic [2:0]          funct3_in,
    input  logic                reg_write_in,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                trap_in,
    input  logic [3:0]          trap_cause_in,
    input  logic                flush,
    output logic                stall_out,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [XLEN-1:0]     dmem_addr,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_wstrb,
    input  logic                dmem_rsp_valid,
    input  logic                dmem_rsp_err,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                wb_reg_write,
    output logic [XLEN-1:0]     wb_pc,
    output logic                wb_trap,
    output logic [3:0]          wb_trap_cause,
    output logic [XLEN-1:0]     wb_badaddr
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    mem_state_e r_state, w_state_nxt;

    logic [XLEN-1:0] r_addr, r_wdata, r_pc;
    logic [NB-1:0]   r_wstrb;
    logic            r_we, r_reg_write;
    logic [4:0]      r_rd;
    logic [2:0]      r_f3;

    logic            r_wb_valid, r_wb_reg_write, r_wb_trap;
    logic [4:0]      r_wb_rd;
    logic [3:0]      r_wb_cause;
    logic [XLEN-1:0] r_wb_data, r_wb_pc, r_wb_badaddr;

    logic            w_accept, w_is_mem, w_is_store, w_illegal, w_misalign;
    logic            w_mem_go, w_handshake, w_rsp_done;
    logic [OW-1:0]   w_off_in;
    logic [NB-1:0]   w_strb_base;
    logic [XLEN-1:0] w_load_data;

    assign stall_out   = (r_state != IDLE);
    assign w_accept    = in_valid & ~stall_out & ~flush;
    assign w_is_mem    = mem_read | mem_write;
    assign w_is_store  = mem_write & ~mem_read;
    assign w_illegal   = f3_illegal(funct3_in, w_is_store, XLEN);
    assign w_off_in    = alu_result[OW-1:0];
    assign w_mem_go    = w_accept & ~trap_in & w_is_mem & ~w_illegal & ~w_misalign;
    assign w_handshake = (r_state == REQ) & dmem_req_ready;
    assign w_rsp_done  = (r_state == WAIT) & dmem_rsp_valid & ~flush;

    always_comb begin
        w_misalign = 1'b0;
        case (funct3_in[1:0])
            2'b01:   w_misalign = alu_result[0];
            2'b10:   w_misalign = |alu_result[1:0];
            2'b11:   w_misalign = |alu_result[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_strb_base = '1;
        case (funct3_in[1:0])
            2'b00:   w_strb_base = NB'(1);
            2'b01:   w_strb_base = NB'(3);
            2'b10:   w_strb_base = NB'(15);
            default: w_strb_base = '1;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_addr[OW-1:0]),
        .i_funct3 (r_f3),
        .o_result (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // A handshake on the flush edge still commits the access, so the
    // response it produces must be swallowed in DRAIN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_mem_go) w_state_nxt = REQ;
            REQ: begin
                if (w_handshake)  w_state_nxt = flush ? DRAIN : WAIT;
                else if (flush)   w_state_nxt = IDLE;
            end
            WAIT: begin
                if (dmem_rsp_valid) w_state_nxt = IDLE;
                else if (flush)     w_state_nxt = DRAIN;
            end
            DRAIN: if (dmem_rsp_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_we           <= 1'b0;
            r_reg_write    <= 1'b0;
            r_rd           <= '0;
            r_f3           <= '0;
            r_pc           <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_trap      <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_cause     <= '0;
            r_wb_data      <= '0;
            r_wb_pc        <= '0;
            r_wb_badaddr   <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_accept) begin
                if (trap_in || (w_is_mem && (w_illegal || w_misalign))) begin
                    r_wb_valid     <= 1'b1;
                    r_wb_rd        <= rd_in;
                    r_wb_pc        <= pc_in;
                    r_wb_data      <= '0;
                    r_wb_reg_write <= 1'b0;
                    r_wb_trap      <= 1'b1;
                    if (trap_in) begin
                        r_wb_cause   <= trap_cause_in;
                        r_wb_badaddr <= '0;
                    end else if (w_illegal) begin
                        r_wb_cause   <= CAUSE_ILLEGAL;
                        r_wb_badaddr <= '0;
                    end else begin
                        r_wb_cause   <= w_is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        r_wb_badaddr <= alu_result;
                    end
                end else if (w_is_mem) begin
                    r_addr      <= alu_result;
                    r_we        <= w_is_store;
                    r_wdata     <= w_is_store ? (rs2_data << {w_off_in, 3'b000}) : '0;
                    r_wstrb     <= w_is_store ? (w_strb_base << w_off_in) : '0;
                    r_f3        <= funct3_in;
                    r_rd        <= rd_in;
                    r_pc        <= pc_in;
                    r_reg_write <= ~w_is_store & reg_write_in;
                end else begin
                    r_wb_valid     <= 1'b1;
                    r_wb_rd        <= rd_in;
                    r_wb_pc        <= pc_in;
                    r_wb_data      <= alu_result;
                    r_wb_reg_write <= reg_write_in;
                    r_wb_trap      <= 1'b0;
                    r_wb_cause     <= '0;
                    r_wb_badaddr   <= '0;
                end
            end
            if (w_rsp_done) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                r_wb_pc    <= r_pc;
                if (dmem_rsp_err) begin
                    r_wb_data      <= '0;
                    r_wb_reg_write <= 1'b0;
                    r_wb_trap      <= 1'b1;
                    r_wb_cause     <= r_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    r_wb_badaddr   <= r_addr;
                end else begin
                    r_wb_data      <= r_we ? '0 : w_load_data;
                    r_wb_reg_write <= r_reg_write;
                    r_wb_trap      <= 1'b0;
                    r_wb_cause     <= '0;
                    r_wb_badaddr   <= '0;
                end
            end
        end
    end

    assign dmem_req_valid = (r_state == REQ);
    assign dmem_addr      = {r_addr[XLEN-1:OW], {OW{1'b0}}};
    assign dmem_we        = r_we;
    assign dmem_wdata     = r_wdata;
    assign dmem_wstrb     = r_wstrb;

    assign wb_valid      = r_wb_valid;
    assign wb_rd         = r_wb_rd;
    assign wb_data       = r_wb_data;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_pc         = r_wb_pc;
    assign wb_trap       = r_wb_trap;
    assign wb_trap_cause = r_wb_cause;
    assign wb_badaddr    = r_wb_badaddr;

    a_rsp_only_when_pending: assert property (@(posedge clk) disable iff (reset)
        dmem_rsp_valid |-> (r_state == WAIT || r_state == DRAIN));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (XLEN=64): inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, reg_write_in, mem_read, mem_write, trap_in, flush;
    logic [63:0] alu_result, rs2_data, pc_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic [3:0]  trap_cause_in;
    logic        stall_out, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_rsp_valid, dmem_rsp_err;
    logic        wb_valid, wb_reg_write, wb_trap;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, wb_pc, wb_badaddr;
    logic [3:0]  wb_trap_cause;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .rs2_data(rs2_data), .pc_in(pc_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .reg_write_in(reg_write_in), .mem_read(mem_read), .mem_write(mem_write),
        .trap_in(trap_in), .trap_cause_in(trap_cause_in), .flush(flush),
        .stall_out(stall_out), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_err(dmem_rsp_err),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_reg_write(wb_reg_write), .wb_pc(wb_pc),
        .wb_trap(wb_trap), .wb_trap_cause(wb_trap_cause), .wb_badaddr(wb_badaddr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Presents one op for a single cycle; returns at the falling edge after accept.
    task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] data,
                            input logic tin, input logic [3:0] tcause);
        in_valid      = 1'b1;
        mem_read      = rd_en;
        mem_write     = wr_en;
        funct3_in     = f3;
        alu_result    = addr;
        rs2_data      = data;
        trap_in       = tin;
        trap_cause_in = tcause;
        reg_write_in  = ~wr_en;
        rd_in         = 5'd5;
        pc_in         = 64'h100;
        @(negedge clk);
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        trap_in   = 1'b0;
    endtask

    // Load with immediate ready and a response one cycle after the handshake.
    task automatic load_test(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] rdata, input logic err, input logic [63:0] exp);
        drive_op(1'b1, 1'b0, f3, addr, 64'h0, 1'b0, 4'd0);
        check({tag, "_req"}, {63'd0, dmem_req_valid}, 64'd1);
        check({tag, "_addr"}, dmem_addr, addr & ~64'h7);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check({tag, "_req_drop"}, {63'd0, dmem_req_valid}, 64'd0);
        dmem_rdata     = rdata;
        dmem_rsp_err   = err;
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_rsp_err   = 1'b0;
        check({tag, "_wbv"}, {63'd0, wb_valid}, 64'd1);
        check({tag, "_data"}, wb_data, exp);
        check({tag, "_trap"}, {63'd0, wb_trap}, {63'd0, err});
        check({tag, "_regw"}, {63'd0, wb_reg_write}, {63'd0, ~err});
        check({tag, "_stall"}, {63'd0, stall_out}, 64'd0);
    endtask

    task automatic trap_test(input string tag, input logic rd_en, input logic wr_en,
                             input logic [2:0] f3, input logic [63:0] addr, input logic tin,
                             input logic [3:0] cause, input logic [63:0] badaddr);
        drive_op(rd_en, wr_en, f3, addr, 64'h55, tin, 4'd3);
        check({tag, "_noreq"}, {63'd0, dmem_req_valid}, 64'd0);
        check({tag, "_wbv"}, {63'd0, wb_valid}, 64'd1);
        check({tag, "_trap"}, {63'd0, wb_trap}, 64'd1);
        check({tag, "_cause"}, {60'd0, wb_trap_cause}, {60'd0, cause});
        check({tag, "_bad"}, wb_badaddr, badaddr);
        check({tag, "_regw"}, {63'd0, wb_reg_write}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; reg_write_in = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; trap_in = 1'b0; flush = 1'b0; alu_result = '0;
        rs2_data = '0; pc_in = '0; rd_in = '0; funct3_in = '0; trap_cause_in = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_err = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", {63'd0, stall_out}, 64'd0);
        check("rst_req", {63'd0, dmem_req_valid}, 64'd0);
        check("rst_wbv", {63'd0, wb_valid}, 64'd0);
        check("rst_addr", dmem_addr, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        load_test("lw", 3'b010, 64'h1004, 64'hDEADBEEF_00000000, 1'b0, 64'hFFFFFFFF_DEADBEEF);
        @(negedge clk);
        check("lw_wb_pulse", {63'd0, wb_valid}, 64'd0);
        load_test("lb",  3'b000, 64'h1007, 64'h80000000_00000000, 1'b0, 64'hFFFFFFFF_FFFFFF80);
        load_test("lbu", 3'b100, 64'h1007, 64'h80000000_00000000, 1'b0, 64'h00000000_00000080);
        load_test("lh",  3'b001, 64'h2002, 64'h00000000_92340000, 1'b0, 64'hFFFFFFFF_FFFF9234);
        load_test("lhu", 3'b101, 64'h2002, 64'h00000000_92340000, 1'b0, 64'h00000000_00009234);
        load_test("lwu", 3'b110, 64'h1004, 64'hDEADBEEF_00000000, 1'b0, 64'h00000000_DEADBEEF);
        load_test("ld",  3'b011, 64'h0010, 64'h01234567_89ABCDEF, 1'b0, 64'h01234567_89ABCDEF);
        load_test("lfault", 3'b010, 64'h4000, 64'h0, 1'b1, 64'h0);
        check("lfault_cause", {60'd0, wb_trap_cause}, 64'd5);
        check("lfault_bad", wb_badaddr, 64'h4000);

        // SH with ready held low for three cycles.
        drive_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("sh_req", {63'd0, dmem_req_valid}, 64'd1);
            check("sh_addr", dmem_addr, 64'h2000);
            check("sh_strb", {56'd0, dmem_wstrb}, 64'hC0);
            check("sh_wdata", dmem_wdata, 64'hABCD0000_00000000);
            check("sh_we", {63'd0, dmem_we}, 64'd1);
            @(negedge clk);
        end
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("sh_wait", {63'd0, stall_out}, 64'd1);
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        check("sh_wbv", {63'd0, wb_valid}, 64'd1);
        check("sh_regw", {63'd0, wb_reg_write}, 64'd0);
        check("sh_trap", {63'd0, wb_trap}, 64'd0);

        trap_test("ld_mis", 1'b1, 1'b0, 3'b011, 64'h3003, 1'b0, 4'd4, 64'h3003);
        trap_test("sw_mis", 1'b0, 1'b1, 3'b010, 64'h3002, 1'b0, 4'd6, 64'h3002);
        trap_test("st_ill", 1'b0, 1'b1, 3'b100, 64'h3000, 1'b0, 4'd2, 64'h0);
        trap_test("ld_ill", 1'b1, 1'b0, 3'b111, 64'h3000, 1'b0, 4'd2, 64'h0);
        trap_test("trapin", 1'b1, 1'b0, 3'b111, 64'h3003, 1'b1, 4'd3, 64'h0);

        // Flush while waiting for the response; the late response is absorbed.
        drive_op(1'b1, 1'b0, 3'b010, 64'h1000, 64'h0, 1'b0, 4'd0);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_wait_stall", {63'd0, stall_out}, 64'd1);
        @(negedge clk);
        check("fl_wait_stall2", {63'd0, stall_out}, 64'd1);
        dmem_rsp_valid = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        check("fl_wait_nowb", {63'd0, wb_valid}, 64'd0);
        check("fl_wait_idle", {63'd0, stall_out}, 64'd0);

        // Flush in REQ without handshake returns straight to IDLE.
        drive_op(1'b1, 1'b0, 3'b010, 64'h1000, 64'h0, 1'b0, 4'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_req_idle", {63'd0, stall_out}, 64'd0);
        check("fl_req_noreq", {63'd0, dmem_req_valid}, 64'd0);
        check("fl_req_nowb", {63'd0, wb_valid}, 64'd0);

        // Flush in IDLE drops the presented op.
        flush = 1'b1;
        drive_op(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 1'b0, 4'd0);
        flush = 1'b0;
        check("fl_idle_nowb", {63'd0, wb_valid}, 64'd0);

        // Five back-to-back plain ALU ops.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; trap_in = 1'b0;
            reg_write_in = 1'b1; rd_in = 5'(i + 1); alu_result = 64'h100 + 64'(i);
            @(negedge clk);
            check("alu_wbv", {63'd0, wb_valid}, 64'd1);
            check("alu_data", wb_data, 64'h100 + 64'(i));
            check("alu_rd", {59'd0, wb_rd}, 64'(i + 1));
            check("alu_stall", {63'd0, stall_out}, 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset while a request is outstanding.
        drive_op(1'b0, 1'b1, 3'b011, 64'h5008, 64'h1234, 1'b0, 4'd0);
        check("rreq_req", {63'd0, dmem_req_valid}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rreq_req0", {63'd0, dmem_req_valid}, 64'd0);
        check("rreq_stall", {63'd0, stall_out}, 64'd0);
        check("rreq_addr", dmem_addr, 64'd0);
        check("rreq_strb", {56'd0, dmem_wstrb}, 64'd0);
        check("rreq_wbdata", wb_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
